// File: rtl/run_ctrl_pkg.sv
// Shared run-control types: run-state encoding and one-hot machine-cycle phase constants.
package cocc_pkg;

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    LOAD   = 2'd3
  } run_state_t;

  localparam logic [2:0] PH_CYCLE = 3'b001;
  localparam logic [2:0] PH_MEM   = 3'b010;
  localparam logic [2:0] PH_INT   = 3'b100;

endpackage

// File: rtl/run_ctrl_if.sv
// Run-control bundle between the CPU top level and the sequencer (slave = run_ctrl).
interface run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run_req;
  logic             step_req;
  logic             halt_req;
  logic             hlt_instr;
  logic             ld_req;
  logic             ld_gnt;
  logic             cycle_en;
  logic             mem_en;
  logic             internal_en;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] cyc_count;

  modport master (
    output run_req, step_req, halt_req, hlt_instr, ld_req,
    input  ld_gnt, cycle_en, mem_en, internal_en, halted, state, cyc_count
  );

  modport slave (
    input  run_req, step_req, halt_req, hlt_instr, ld_req,
    output ld_gnt, cycle_en, mem_en, internal_en, halted, state, cyc_count
  );
endinterface

// File: rtl/run_ctrl_phase_ring.sv
// Three-phase one-hot ring: rotates one step per clock when adv_i, forced to PH_CYCLE when park_i.
// Park wins over advance so an idle CPU always restarts a machine cycle from its first phase.
module phase_ring
  import cocc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       adv_i,
  input  logic       park_i,
  output logic [2:0] phase_o
);

  logic [2:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (park_i) begin
      phase_d = PH_CYCLE;
    end else if (adv_i) begin
      phase_d = {phase_q[1:0], phase_q[2]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= PH_CYCLE;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/run_ctrl.sv
// Run-control sequencer: free run / single step / halt / loader park, phase strobes one per clock.
// Optional completed-cycle counter is built only when RUN_CTRL_CYCCNT_EN is defined.
module run_ctrl
  import cocc_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter bit RESET_RUN = 1'b0
) (
  input  logic     clk,
  input  logic     reset,
  run_ctrl_if.slave bus
);

  localparam run_state_t RST_STATE = RESET_RUN ? RUN : HALTED;

  run_state_t state_q, state_d;
  logic       pend_q, pend_d;
  logic [2:0] phase;
  logic       active_st;
  logic       run_act;

  assign active_st = (state_q == RUN) || (state_q == STEP);

  phase_ring u_ring (
    .clk     (clk),
    .reset   (reset),
    .adv_i   (active_st),
    .park_i  (!active_st),
    .phase_o (phase)
  );

  // Halts are only ever taken at the internal phase so a started cycle always completes.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      HALTED: begin
        if (bus.run_req) begin
          state_d = RUN;
        end else if (bus.step_req) begin
          state_d = STEP;
        end else if (bus.ld_req) begin
          state_d = LOAD;
        end
      end
      RUN: begin
        if (phase == PH_INT) begin
          pend_d = 1'b0;
          if (pend_q || bus.halt_req || bus.hlt_instr) begin
            state_d = HALTED;
          end
        end else begin
          pend_d = pend_q || bus.halt_req;
        end
      end
      STEP: begin
        if (phase == PH_INT) begin
          state_d = HALTED;
        end
      end
      LOAD: begin
        if (!bus.ld_req) begin
          state_d = HALTED;
        end
      end
      default: state_d = HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RST_STATE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Reset gates the outputs combinationally so an abort drops strobes and grant in the same cycle.
  assign run_act         = reset && active_st;
  assign bus.cycle_en    = run_act && (phase == PH_CYCLE);
  assign bus.mem_en      = run_act && (phase == PH_MEM);
  assign bus.internal_en = run_act && (phase == PH_INT);
  assign bus.ld_gnt      = reset && (state_q == LOAD);
  assign bus.halted      = reset ? (state_q == HALTED) : !RESET_RUN;
  assign bus.state       = state_q;

`ifdef RUN_CTRL_CYCCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = bus.internal_en ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.cyc_count = cnt_q;
`else
  assign bus.cyc_count = '0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed scenarios plus randomized traffic against a phase-position model.
module tb_run_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   passes;

  run_ctrl_if #(.CNT_W(16)) bus ();

  run_ctrl #(.CNT_W(16), .RESET_RUN(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode 0=halted 1=run 2=step 3=load, pos = phase index within the machine cycle.
  int          m_mode;
  int          m_pos;
  bit          m_pend;
  logic [15:0] m_cnt;

  function automatic logic [22:0] obs_vec();
    return {bus.ld_gnt, bus.cycle_en, bus.mem_en, bus.internal_en,
            bus.halted, bus.state, bus.cyc_count};
  endfunction

  function automatic logic [22:0] exp_vec();
    logic        running;
    logic [15:0] cnt_e;
    running = reset && (m_mode == 1 || m_mode == 2);
`ifdef RUN_CTRL_CYCCNT_EN
    cnt_e = m_cnt;
`else
    cnt_e = 16'd0;
`endif
    return {reset && (m_mode == 3), running && (m_pos == 0), running && (m_pos == 1),
            running && (m_pos == 2), reset ? (m_mode == 0) : 1'b1, 2'(m_mode), cnt_e};
  endfunction

  function automatic logic [15:0] cnt_exp(input int n);
`ifdef RUN_CTRL_CYCCNT_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  task automatic model_step();
    if (!reset) begin
      m_mode = 0; m_pos = 0; m_pend = 0; m_cnt = 16'd0;
    end else begin
      case (m_mode)
        0: begin
          if (bus.run_req)       m_mode = 1;
          else if (bus.step_req) m_mode = 2;
          else if (bus.ld_req)   m_mode = 3;
        end
        1: begin
          if (m_pos == 2) begin
            m_cnt = m_cnt + 16'd1;
            if (m_pend || bus.halt_req || bus.hlt_instr) m_mode = 0;
            m_pend = 0;
          end else if (bus.halt_req) begin
            m_pend = 1;
          end
          m_pos = (m_pos + 1) % 3;
        end
        2: begin
          if (m_pos == 2) begin
            m_cnt = m_cnt + 16'd1;
            m_mode = 0;
          end
          m_pos = (m_pos + 1) % 3;
        end
        default: if (!bus.ld_req) m_mode = 0;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    if (bus.halted !== 1'b1 || bus.ld_gnt !== 1'b0 || {bus.cycle_en, bus.mem_en, bus.internal_en} !== 3'b000) begin
      $display("FAIL reset_low got halted=%b gnt=%b strobes=%b%b%b need 1 0 000",
               bus.halted, bus.ld_gnt, bus.cycle_en, bus.mem_en, bus.internal_en);
    end else passes++;
    checks++;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_vec() !== exp_vec()) $display("FAIL reset_idle got=%h need=%h", obs_vec(), exp_vec());
      else passes++;
      checks++;
    end
    if ({bus.halted, bus.state, bus.cyc_count} !== {1'b1, 2'd0, 16'd0}) begin
      $display("FAIL reset_values got halted=%b state=%0d cnt=%0d", bus.halted, bus.state, bus.cyc_count);
    end else passes++;
    checks++;
  endtask

  task automatic test_run();
    logic [2:0] want;
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      want = (i % 3 == 0) ? 3'b100 : (i % 3 == 1) ? 3'b010 : 3'b001;
      if ({bus.cycle_en, bus.mem_en, bus.internal_en} !== want || obs_vec() !== exp_vec()) begin
        $display("FAIL run_pattern i=%0d got strobes=%b vec=%h need strobes=%b vec=%h",
                 i, {bus.cycle_en, bus.mem_en, bus.internal_en}, obs_vec(), want, exp_vec());
      end else passes++;
      checks++;
      tick();
    end
    if (bus.cycle_en !== 1'b1 || bus.cyc_count !== cnt_exp(3)) begin
      $display("FAIL run_count got cycle_en=%b cnt=%0d need 1 %0d", bus.cycle_en, bus.cyc_count, cnt_exp(3));
    end else passes++;
    checks++;
  endtask

  task automatic test_halt_req();
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    if (bus.mem_en !== 1'b1 || bus.halted !== 1'b0) begin
      $display("FAIL halt_midcycle got mem_en=%b halted=%b need 1 0", bus.mem_en, bus.halted);
    end else passes++;
    checks++;
    tick();
    if (bus.internal_en !== 1'b1) $display("FAIL halt_int got internal_en=%b need 1", bus.internal_en);
    else passes++;
    checks++;
    tick();
    if ({bus.halted, bus.cycle_en, bus.mem_en, bus.internal_en} !== 4'b1000 || bus.cyc_count !== cnt_exp(4)) begin
      $display("FAIL halt_taken got halted/strobes=%b%b%b%b cnt=%0d need 1000 %0d",
               bus.halted, bus.cycle_en, bus.mem_en, bus.internal_en, bus.cyc_count, cnt_exp(4));
    end else passes++;
    checks++;
  endtask

  task automatic test_step();
    int nc, nm, ni;
    nc = 0; nm = 0; ni = 0;
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nc += int'(bus.cycle_en); nm += int'(bus.mem_en); ni += int'(bus.internal_en);
      if (obs_vec() !== exp_vec()) $display("FAIL step_model i=%0d got=%h need=%h", i, obs_vec(), exp_vec());
      else passes++;
      checks++;
      tick();
    end
    if (nc != 1 || nm != 1 || ni != 1 || bus.halted !== 1'b1 || bus.cyc_count !== cnt_exp(5)) begin
      $display("FAIL step_once got c=%0d m=%0d i=%0d halted=%b cnt=%0d need 1 1 1 1 %0d",
               nc, nm, ni, bus.halted, bus.cyc_count, cnt_exp(5));
    end else passes++;
    checks++;
  endtask

  task automatic test_hlt_instr();
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    tick();
    bus.hlt_instr = 1'b1;
    tick();
    bus.hlt_instr = 1'b0;
    tick();
    if (bus.halted !== 1'b0 || bus.cycle_en !== 1'b1) begin
      $display("FAIL hlt_at_mem got halted=%b cycle_en=%b need 0 1", bus.halted, bus.cycle_en);
    end else passes++;
    checks++;
    tick();
    tick();
    bus.hlt_instr = 1'b1;
    tick();
    bus.hlt_instr = 1'b0;
    if (bus.halted !== 1'b1 || bus.cyc_count !== cnt_exp(7) || obs_vec() !== exp_vec()) begin
      $display("FAIL hlt_at_int got halted=%b cnt=%0d vec=%h need 1 %0d vec=%h",
               bus.halted, bus.cyc_count, obs_vec(), cnt_exp(7), exp_vec());
    end else passes++;
    checks++;
  endtask

  task automatic test_load();
    int ngnt, nstb;
    ngnt = 0; nstb = 0;
    bus.ld_req = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      ngnt += int'(bus.ld_gnt);
      nstb += int'(bus.cycle_en) + int'(bus.mem_en) + int'(bus.internal_en);
      if (i == 4) bus.ld_req = 1'b0;
      bus.run_req = (i == 2);
      tick();
    end
    if (ngnt != 5 || nstb != 0 || bus.ld_gnt !== 1'b0 || bus.halted !== 1'b1) begin
      $display("FAIL load_window got gnt=%0d strobes=%0d gnt_now=%b halted=%b need 5 0 0 1",
               ngnt, nstb, bus.ld_gnt, bus.halted);
    end else passes++;
    checks++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.halted !== 1'b1 || obs_vec() !== exp_vec()) begin
        $display("FAIL load_run_ignored got=%h need=%h", obs_vec(), exp_vec());
      end else passes++;
      checks++;
    end
  endtask

  task automatic test_reset_abort();
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    if ({bus.cycle_en, bus.mem_en, bus.internal_en} !== 3'b000) begin
      $display("FAIL abort_run got strobes=%b%b%b need 000", bus.cycle_en, bus.mem_en, bus.internal_en);
    end else passes++;
    checks++;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs_vec() !== exp_vec()) $display("FAIL abort_run_after got=%h need=%h", obs_vec(), exp_vec());
      else passes++;
      checks++;
    end
    bus.ld_req = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    if (bus.ld_gnt !== 1'b0) $display("FAIL abort_load got ld_gnt=%b need 0", bus.ld_gnt);
    else passes++;
    checks++;
    bus.ld_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    if (obs_vec() !== exp_vec()) $display("FAIL abort_load_after got=%h need=%h", obs_vec(), exp_vec());
    else passes++;
    checks++;
  endtask

  task automatic test_random();
    int nstb;
    for (int i = 0; i < 800; i++) begin
      reset         = ($urandom_range(0, 63) != 0);
      bus.run_req   = ($urandom_range(0, 7) == 0);
      bus.step_req  = ($urandom_range(0, 7) == 0);
      bus.halt_req  = ($urandom_range(0, 9) == 0);
      bus.hlt_instr = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) bus.ld_req = !bus.ld_req;
      tick();
      nstb = int'(bus.cycle_en) + int'(bus.mem_en) + int'(bus.internal_en);
      if (obs_vec() !== exp_vec() || (bus.ld_gnt && bus.mem_en) ||
          nstb != ((reset && (m_mode == 1 || m_mode == 2)) ? 1 : 0)) begin
        $display("FAIL random i=%0d got=%h need=%h strobes=%0d", i, obs_vec(), exp_vec(), nstb);
      end else passes++;
      checks++;
    end
  endtask

  initial begin
    checks = 0; passes = 0;
    m_mode = 0; m_pos = 0; m_pend = 0; m_cnt = 16'd0;
    reset = 1'b0;
    bus.run_req = 1'b0; bus.step_req = 1'b0; bus.halt_req = 1'b0;
    bus.hlt_instr = 1'b0; bus.ld_req = 1'b0;
    test_reset();
    test_run();
    test_halt_req();
    test_step();
    test_hlt_instr();
    test_load();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run-control sequencer for the COCC CPU core. It owns the three-phase machine cycle (cycle, memory, internal) and decides when each phase strobe fires: free run, single step, halt on request or on a decoded HLT instruction, and a loader mode that hands the RAM port to an external loader while the CPU is parked. It sits between the top-level clock/reset and every phase-enabled register in the datapath.

## Interface

Parameters:
- CNT_W, 16, width of the completed-machine-cycle counter
- RESET_RUN, 0, 1 = enter RUN after reset, 0 = enter HALTED

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- run_req  in  1  request free running
- step_req  in  1  request exactly one machine cycle
- halt_req  in  1  external halt request
- hlt_instr  in  1  CPU decoded HLT; sampled only in the internal-phase strobe cycle
- ld_req  in  1  loader requests RAM ownership; level, held for the whole access
- ld_gnt  out  1  loader owns RAM
- cycle_en  out  1  phase-1 strobe
- mem_en  out  1  phase-2 strobe (RAM access slot)
- internal_en  out  1  phase-3 strobe
- halted  out  1  state == HALTED
- state  out  2  current FSM state encoding
- cyc_count  out  CNT_W  completed machine cycles, wraps

## Operation

- Phase ring: one-hot PH_CYCLE → PH_MEM → PH_INT → PH_CYCLE.
  - Advances one step per clk only in RUN or STEP.
  - Parked at PH_CYCLE in HALTED and LOAD.
- Strobes:
  - Strobe = (phase matches) & (state is RUN or STEP) & reset high.
  - Exactly one strobe is high in any cycle; none in HALTED or LOAD.
- FSM states: HALTED=0, RUN=1, STEP=2, LOAD=3.
  - HALTED: run_req → RUN; else step_req → STEP; else ld_req → LOAD. Priority run > step > ld. halt_req is ignored.
  - RUN: halt_req at any phase sets halt_pend. At PH_INT, halt_pend | hlt_instr → HALTED, and halt_pend clears. run_req, step_req and ld_req are ignored.
  - STEP: runs one full machine cycle. At PH_INT → HALTED unconditionally. halt_req and hlt_instr have no extra effect.
  - LOAD: ld_gnt=1. ld_req low → HALTED. run_req and step_req are ignored until back in HALTED.
- A halt is never taken mid-cycle. A machine cycle, once started, always completes all three phases.
- cyc_count increments by 1 in every cycle where internal_en=1. It wraps from 2^CNT_W−1 to 0.

## Timing

- Register values after the reset edge:
  - state = RESET_RUN ? RUN : HALTED
  - phase = PH_CYCLE
  - halt_pend = 0
  - cyc_count = 0
- Outputs:
  - ld_gnt = 0 while reset is low.
  - All strobes = 0 while reset is low.
  - halted = !RESET_RUN.
- Reset mid-cycle or mid-LOAD aborts immediately. No further strobes fire; ld_gnt drops in the same cycle.
- run_req/step_req sampled at edge N in HALTED → cycle_en high in cycle N+1.
- Machine cycle = 3 clocks. In RUN with no halt, strobes are periodic: cycle, mem, internal, cycle, …
- Halt latency: decided at PH_INT edge N → halted=1 in cycle N+1. No strobe fires in N+1.
- ld_req sampled at edge N in HALTED → ld_gnt=1 in cycle N+1.
- ld_req low at edge M → ld_gnt=0 in cycle M+1.
- ld_gnt and mem_en are never high together.

## Configuration

- RUN_CTRL_CYCCNT_EN defined: the cyc_count register and incrementer are built.
- RUN_CTRL_CYCCNT_EN undefined: no counter logic is built, and cyc_count is tied to 0. All other behaviour is identical.

## Structure

- Shared package cocc_pkg holds:
  - run-state typedef (HALTED, RUN, STEP, LOAD, 2-bit)
  - one-hot phase constants PH_CYCLE=3'b001, PH_MEM=3'b010, PH_INT=3'b100
- One sub-module, phase_ring: 3-bit one-hot ring with advance enable and park-to-PH_CYCLE input.
- The run_ctrl top holds the FSM, halt_pend, the counter and the strobe decode.

## Test plan

- Reset with RESET_RUN=0, release, idle 10 clocks → halted=1, all strobes 0, cyc_count=0.
- run_req pulse, then 9 clocks → strobes repeat cycle/mem/internal 3 times, cyc_count=3.
- halt_req pulse during PH_CYCLE of cycle 4 → that cycle completes; halted=1 after its internal_en; cyc_count=4.
- step_req from HALTED → exactly one each of cycle_en, mem_en, internal_en, then halted=1.
- RUN with hlt_instr=1 asserted only at PH_MEM → no halt. Asserted at PH_INT → halted next clock.
- ld_req held 5 clocks from HALTED, run_req pulsed during LOAD → ld_gnt high for 5 cycles, no strobes, state returns to HALTED; the run_req is ignored.
